// File: rtl/sprite_blitter.sv
// Sprite blitter: walks a SPR_W x SPR_H sprite ROM in raster order and emits
// clipped, oriented pixel writes for a VGA adapter through a 3-stage pipeline.
module sprite_blitter #(
    parameter int SPR_W   = 8,
    parameter int SPR_H   = 14,
    parameter int COLOR_W = 9,
    parameter int X_MAX   = 160,
    parameter int Y_MAX   = 120,
    parameter int ADDR_W  = $clog2(SPR_W * SPR_H)
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iStart,
    input  logic [7:0]         iX,
    input  logic [6:0]         iY,
    input  logic [2:0]         iDir,
    input  logic               iErase,
    input  logic [COLOR_W-1:0] iBgColour,
    output logic [ADDR_W-1:0]  oRomAddr,
    input  logic [COLOR_W:0]   iRomData,
    output logic [7:0]         oX,
    output logic [6:0]         oY,
    output logic [COLOR_W-1:0] oColour,
    output logic               oPlot,
    output logic               oBusy,
    output logic               oDone
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPR_H - 1);
    localparam logic [7:0]    W_M1     = 8'(SPR_W - 1);
    localparam logic [7:0]    H_M1     = 8'(SPR_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t              state;
    logic                flush_second;
    logic [CW-1:0]       col, s1_col;
    logic [RW-1:0]       row, s1_row;
    logic                s1_valid;
    logic [7:0]          lat_x;
    logic [6:0]          lat_y;
    logic [2:0]          lat_dir;
    logic                lat_erase;
    logic [COLOR_W-1:0]  lat_bg;

    logic [7:0] c8, r8, dx, dy;
    logic [8:0] sum_x, sum_y;
    logic       on_screen;

    // Orientation and clipping for the index whose ROM word is arriving now.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value held and infer a latch.
        dx = '0;
        dy = '0;
        c8 = 8'(s1_col);
        r8 = 8'(s1_row);
        case (lat_dir)
            3'd0:    begin dx = c8;        dy = r8;        end
            3'd1:    begin dx = H_M1 - r8; dy = c8;        end
            3'd2:    begin dx = W_M1 - c8; dy = H_M1 - r8; end
            3'd3:    begin dx = r8;        dy = W_M1 - c8; end
            3'd4:    begin dx = W_M1 - c8; dy = r8;        end
            3'd5:    begin dx = c8;        dy = H_M1 - r8; end
            3'd6:    begin dx = r8;        dy = c8;        end
            default: begin dx = H_M1 - r8; dy = W_M1 - c8; end
        endcase
        // One bit wider than the operands: off-screen sums never wrap back.
        sum_x     = {1'b0, lat_x} + {1'b0, dx};
        sum_y     = {2'b00, lat_y} + {1'b0, dy};
        on_screen = (sum_x < 9'(X_MAX)) && (sum_y < 9'(Y_MAX));
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values and the pipeline stages stay one cycle apart.
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state        <= IDLE;
            flush_second <= 1'b0;
            row          <= '0;
            col          <= '0;
            s1_row       <= '0;
            s1_col       <= '0;
            s1_valid     <= 1'b0;
            lat_x        <= '0;
            lat_y        <= '0;
            lat_dir      <= '0;
            lat_erase    <= 1'b0;
            lat_bg       <= '0;
            oRomAddr     <= '0;
            oX           <= '0;
            oY           <= '0;
            oColour      <= '0;
            oPlot        <= 1'b0;
            oBusy        <= 1'b0;
            oDone        <= 1'b0;
        end else begin
            // Stage 1 tracks which index the ROM word belongs to; stage 2 is the output.
            s1_valid <= (state == RUN);
            s1_row   <= row;
            s1_col   <= col;
            oPlot    <= s1_valid && iRomData[COLOR_W] && on_screen;
            oX       <= sum_x[7:0];
            oY       <= sum_y[6:0];
            oColour  <= lat_erase ? lat_bg : iRomData[COLOR_W-1:0];
            oDone    <= 1'b0;

            case (state)
                IDLE: begin
                    if (iStart) begin
                        lat_x     <= iX;
                        lat_y     <= iY;
                        lat_dir   <= iDir;
                        lat_erase <= iErase;
                        lat_bg    <= iBgColour;
                        row       <= '0;
                        col       <= '0;
                        oRomAddr  <= '0;
                        oBusy     <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (row == ROW_LAST && col == COL_LAST) begin
                        row          <= '0;
                        col          <= '0;
                        oRomAddr     <= '0;
                        flush_second <= 1'b0;
                        state        <= FLUSH;
                    end else begin
                        oRomAddr <= oRomAddr + ADDR_W'(1);
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (flush_second) begin
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                        state <= DONE;
                    end else begin
                        flush_second <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: a bench-side ROM, a raster/orientation
// model of expected pixels per cycle, directed scenarios and randomized draws.
module tb_sprite_blitter;

    localparam int SPR_W   = 8;
    localparam int SPR_H   = 14;
    localparam int COLOR_W = 9;
    localparam int X_MAX   = 160;
    localparam int Y_MAX   = 120;
    localparam int N       = SPR_W * SPR_H;
    localparam int ADDR_W  = $clog2(N);

    logic               iClock = 1'b0;
    logic               iReset;
    logic               iStart;
    logic [7:0]         iX;
    logic [6:0]         iY;
    logic [2:0]         iDir;
    logic               iErase;
    logic [COLOR_W-1:0] iBgColour;
    logic [ADDR_W-1:0]  oRomAddr;
    logic [COLOR_W:0]   iRomData;
    logic [7:0]         oX;
    logic [6:0]         oY;
    logic [COLOR_W-1:0] oColour;
    logic               oPlot;
    logic               oBusy;
    logic               oDone;

    sprite_blitter #(
        .SPR_W(SPR_W), .SPR_H(SPR_H), .COLOR_W(COLOR_W),
        .X_MAX(X_MAX), .Y_MAX(Y_MAX), .ADDR_W(ADDR_W)
    ) dut (
        .iClock(iClock), .iReset(iReset), .iStart(iStart),
        .iX(iX), .iY(iY), .iDir(iDir), .iErase(iErase), .iBgColour(iBgColour),
        .oRomAddr(oRomAddr), .iRomData(iRomData),
        .oX(oX), .oY(oY), .oColour(oColour),
        .oPlot(oPlot), .oBusy(oBusy), .oDone(oDone)
    );

    always #5 iClock = ~iClock;

    // Sprite ROM with one cycle of read latency.
    logic [COLOR_W:0] rom [N];
    always @(posedge iClock) iRomData <= rom[oRomAddr];

    int n_cmp  = 0;
    int n_fail = 0;

    // Statistics of the most recent draw, gathered from the DUT outputs.
    int st_plots, st_dups, st_minx, st_maxx, st_miny, st_maxy;
    int st_done_cnt, st_done_cyc, st_k0x, st_k0y, st_nonzero_col;
    bit seen [X_MAX][Y_MAX];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Destination offset of sprite pixel (r,c) for orientation dir.
    function automatic void orient(input int dir, input int r, input int c,
                                   output int dx, output int dy);
        case (dir)
            0: begin dx = c;             dy = r;             end
            1: begin dx = SPR_H - 1 - r; dy = c;             end
            2: begin dx = SPR_W - 1 - c; dy = SPR_H - 1 - r; end
            3: begin dx = r;             dy = SPR_W - 1 - c; end
            4: begin dx = SPR_W - 1 - c; dy = r;             end
            5: begin dx = c;             dy = SPR_H - 1 - r; end
            6: begin dx = r;             dy = c;             end
            default: begin dx = SPR_H - 1 - r; dy = SPR_W - 1 - c; end
        endcase
    endfunction

    // mode 0: all opaque, 1: checkerboard opaque, 2: random opacity
    task automatic fill_rom(input int mode);
        for (int k = 0; k < N; k++) begin
            logic opq;
            case (mode)
                0:       opq = 1'b1;
                1:       opq = (((k / SPR_W) + (k % SPR_W)) % 2) == 0;
                default: opq = ($urandom_range(0, 9) < 7);
            endcase
            rom[k] = {opq, COLOR_W'($urandom)};
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_plot"},   32'(oPlot),    0);
        check({tag, "_busy"},   32'(oBusy),    0);
        check({tag, "_done"},   32'(oDone),    0);
        check({tag, "_addr"},   32'(oRomAddr), 0);
        check({tag, "_x"},      32'(oX),       0);
        check({tag, "_y"},      32'(oY),       0);
        check({tag, "_colour"}, 32'(oColour),  0);
    endtask

    // One draw; cycle 1 is the cycle right after the start edge.
    // hold keeps iStart high throughout, rst_cyc>0 resets in that cycle,
    // poke_cyc>0 pulses iStart in that cycle while busy.
    task automatic run_draw(input int x, input int y, input int dir, input int erase,
                            input int bg, input bit hold, input int rst_cyc, input int poke_cyc);
        bit e_plot [N];
        int e_x [N];
        int e_y [N];
        int e_col [N];
        int dx, dy;

        for (int k = 0; k < N; k++) begin
            orient(dir, k / SPR_W, k % SPR_W, dx, dy);
            e_x[k]    = x + dx;
            e_y[k]    = y + dy;
            e_plot[k] = rom[k][COLOR_W] && (e_x[k] < X_MAX) && (e_y[k] < Y_MAX);
            e_col[k]  = erase ? bg : int'(rom[k][COLOR_W-1:0]);
        end
        st_plots = 0; st_dups = 0; st_done_cnt = 0; st_done_cyc = -1;
        st_minx = 999; st_maxx = -1; st_miny = 999; st_maxy = -1;
        st_k0x = -1; st_k0y = -1; st_nonzero_col = 0;
        for (int i = 0; i < X_MAX; i++)
            for (int j = 0; j < Y_MAX; j++) seen[i][j] = 1'b0;

        @(negedge iClock);
        check("idle_busy", 32'(oBusy), 0);
        check("idle_done", 32'(oDone), 0);
        iX        = 8'(x);
        iY        = 7'(y);
        iDir      = 3'(dir);
        iErase    = 1'(erase);
        iBgColour = COLOR_W'(bg);
        iStart    = 1'b1;
        @(posedge iClock);

        for (int cyc = 1; cyc <= N + 3; cyc++) begin
            int k;
            @(negedge iClock);
            if (cyc == rst_cyc) begin
                iStart = 1'b0;
                iReset = 1'b1;
                #1;
                check_reset_outputs("abort");
                repeat (3) begin
                    @(negedge iClock);
                    check("abort_hold_plot", 32'(oPlot), 0);
                    check("abort_hold_done", 32'(oDone), 0);
                    check("abort_hold_busy", 32'(oBusy), 0);
                end
                iReset = 1'b0;
                repeat (3) begin
                    @(negedge iClock);
                    check("post_abort_busy", 32'(oBusy), 0);
                    check("post_abort_done", 32'(oDone), 0);
                    check("post_abort_plot", 32'(oPlot), 0);
                end
                return;
            end

            k = cyc - 3;
            check("busy", 32'(oBusy), 32'(cyc <= N + 2));
            check("done", 32'(oDone), 32'(cyc == N + 3));
            if (k >= 0 && k < N) begin
                check("plot", 32'(oPlot), 32'(e_plot[k]));
                if (e_plot[k] && oPlot) begin
                    check("pix_x",      32'(oX),      32'(e_x[k]));
                    check("pix_y",      32'(oY),      32'(e_y[k]));
                    check("pix_colour", 32'(oColour), 32'(e_col[k]));
                end
            end else begin
                check("plot_idle", 32'(oPlot), 0);
            end

            if (oPlot) begin
                st_plots++;
                if (oX < X_MAX && oY < Y_MAX) begin
                    if (seen[oX][oY]) st_dups++;
                    seen[oX][oY] = 1'b1;
                end
                if (int'(oX) < st_minx) st_minx = oX;
                if (int'(oX) > st_maxx) st_maxx = oX;
                if (int'(oY) < st_miny) st_miny = oY;
                if (int'(oY) > st_maxy) st_maxy = oY;
                if (oColour != 0) st_nonzero_col++;
                if (cyc == 3) begin st_k0x = oX; st_k0y = oY; end
            end
            if (oDone) begin
                st_done_cnt++;
                st_done_cyc = cyc;
            end

            // Inputs after the start edge must not disturb the draw.
            iStart    = hold ? 1'b1 : (cyc == poke_cyc);
            iX        = 8'($urandom);
            iY        = 7'($urandom);
            iDir      = 3'($urandom);
            iErase    = 1'($urandom);
            iBgColour = COLOR_W'($urandom);
        end
        if (!hold) iStart = 1'b0;
    endtask

    initial begin
        iReset = 1'b1; iStart = 1'b0; iX = '0; iY = '0; iDir = '0;
        iErase = 1'b0; iBgColour = '0;
        fill_rom(0);
        repeat (3) @(negedge iClock);
        check_reset_outputs("reset");
        iReset = 1'b0;
        repeat (2) @(negedge iClock);

        // All opaque, upright.
        run_draw(10, 20, 0, 0, 0, 1'b0, 0, 0);
        check("s1_plots", st_plots, 112);
        check("s1_dups",  st_dups, 0);
        check("s1_minx",  st_minx, 10);
        check("s1_maxx",  st_maxx, 17);
        check("s1_miny",  st_miny, 20);
        check("s1_maxy",  st_maxy, 33);
        check("s1_done_cyc", st_done_cyc, 115);
        check("s1_done_cnt", st_done_cnt, 1);

        // Rotated footprint.
        run_draw(10, 20, 1, 0, 0, 1'b0, 0, 0);
        check("s2_plots", st_plots, 112);
        check("s2_minx",  st_minx, 10);
        check("s2_maxx",  st_maxx, 23);
        check("s2_miny",  st_miny, 20);
        check("s2_maxy",  st_maxy, 27);
        check("s2_k0x",   st_k0x, 23);
        check("s2_k0y",   st_k0y, 20);

        // Clipped at the bottom-right corner.
        run_draw(156, 115, 0, 0, 0, 1'b0, 0, 0);
        check("s3_plots", st_plots, 20);
        check("s3_minx",  st_minx, 156);
        check("s3_maxx",  st_maxx, 159);
        check("s3_miny",  st_miny, 115);
        check("s3_maxy",  st_maxy, 119);
        check("s3_done_cyc", st_done_cyc, 115);

        // Checkerboard erase.
        fill_rom(1);
        run_draw(40, 50, 0, 1, 0, 1'b0, 0, 0);
        check("s4_plots", st_plots, 56);
        check("s4_nonzero_colour", st_nonzero_col, 0);

        // Reset mid-draw, then a clean draw.
        fill_rom(2);
        run_draw(30, 30, 2, 0, 0, 1'b0, 50, 0);
        check("s5_no_done", st_done_cnt, 0);
        run_draw(30, 30, 2, 0, 0, 1'b0, 0, 0);
        check("s5_redo_done_cyc", st_done_cyc, 115);

        // Start pulse while busy is ignored.
        run_draw(5, 5, 3, 0, 0, 1'b0, 0, 30);
        check("s6_done_cnt", st_done_cnt, 1);
        repeat (3) begin
            @(negedge iClock);
            check("s6_stays_idle", 32'(oBusy), 0);
        end

        // Start held through DONE chains straight into the next draw.
        run_draw(100, 90, 7, 1, 9'h1a5, 1'b1, 0, 0);
        check("s7_done_cnt", st_done_cnt, 1);
        run_draw(150, 100, 5, 0, 0, 1'b0, 0, 0);
        check("s7_next_done_cyc", st_done_cyc, 115);

        // Randomized draws.
        for (int t = 0; t < 8; t++) begin
            fill_rom(2);
            run_draw(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                     int'($urandom_range(0, 511)), 1'b0, 0, 0);
            check("rand_done_cyc", st_done_cyc, 115);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
